// File: rtl/rng_share_sched_if.sv
// rng_share_sched_if
//   Bundle between the uBrain compute tiles (master side) and the shared
//   RNG scheduler (slave side).
//   master: drives req/cfgLen/abort, observes grant/grantIdx/rngEnable/valid/done/busy
//   slave : the scheduler; samples req/cfgLen/abort, drives the rest
//   req       - level request, one bit per requester
//   cfgLen    - window length, sampled at grant (0 means 2^RWID cycles)
//   abort     - terminate the current window without a done pulse
//   grant     - one-hot owner, held for the whole window
//   grantIdx  - binary index of the owner
//   rngEnable - enable for the Sobol RNG buffer array
//   valid     - buffered RNG output is meaningful for the owner this cycle
//   done      - one-cycle pulse to the owner on normal completion
//   busy      - scheduler is not idle
interface rng_share_sched_if #(
  parameter int NREQ = 4,
  parameter int RWID = 10,
  parameter int IWID = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] req;
  logic [RWID-1:0] cfgLen;
  logic            abort;
  logic [NREQ-1:0] grant;
  logic [IWID-1:0] grantIdx;
  logic            rngEnable;
  logic            valid;
  logic [NREQ-1:0] done;
  logic            busy;

  modport master (
    output req, cfgLen, abort,
    input  grant, grantIdx, rngEnable, valid, done, busy
  );

  modport slave (
    input  req, cfgLen, abort,
    output grant, grantIdx, rngEnable, valid, done, busy
  );
endinterface

// File: rtl/rng_share_sched.sv
// rng_share_sched
//   Round-robin owner scheduler for the shared Sobol RNG buffer array.
//   One requester at a time gets a window of L RNG-enable cycles
//   (L = cfgLen, or 2^RWID when cfgLen is 0). valid follows rngEnable by
//   the one-cycle buffer delay of the RNG array, and done pulses to the
//   owner together with the last valid sample.
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset
//     bus   - rng_share_sched_if slave modport (requests, grant, status)
module rng_share_sched #(
  parameter int NREQ = 4,
  parameter int RWID = 10,
  parameter int IWID = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic              clk,
  input logic              rst_n,
  rng_share_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [IWID:0] NREQ_W = NREQ[IWID:0];

  state_t          state_q;
  logic [RWID-1:0] cnt_q;
  logic [RWID-1:0] len_q;
  logic [IWID-1:0] rr_ptr_q;
  logic [IWID-1:0] grant_idx_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            rng_en_q;
  logic            valid_q;
  logic            busy_q;

  // (a + b) mod NREQ for operands already below NREQ.
  function automatic logic [IWID-1:0] wrap_add(input logic [IWID-1:0] a,
                                               input logic [IWID-1:0] b);
    logic [IWID:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREQ_W) s = s - NREQ_W;
    return s[IWID-1:0];
  endfunction

  // Rotate requests so the rrPtr slot lands at bit 0; the lowest set bit of
  // the rotated vector is then the round-robin winner's offset from rrPtr.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IWID-1:0]   win_ofs;
  logic              win_found;
  logic [IWID-1:0]   win_idx;
  logic [IWID-1:0]   rr_next;
  logic [NREQ-1:0]   win_onehot;

  assign req_dbl = {bus.req, bus.req} >> rr_ptr_q;
  assign req_rot = req_dbl[NREQ-1:0];

  always_comb begin
    win_ofs   = '0;
    win_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_ofs   = IWID'(i);
        win_found = 1'b1;
      end
    end
  end

  assign win_idx = wrap_add(rr_ptr_q, win_ofs);
  assign rr_next = wrap_add(win_idx, IWID'(1));

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == IWID'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rng_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Mirrors the one-cycle buffer delay of the RNG array.
      valid_q <= rng_en_q && (grant_q != '0);
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          // abort in IDLE suppresses arbitration for this cycle
          if (!bus.abort && win_found) begin
            state_q     <= RUN;
            grant_q     <= win_onehot;
            grant_idx_q <= win_idx;
            len_q       <= bus.cfgLen;
            cnt_q       <= '0;
            rng_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            rr_ptr_q    <= rr_next;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rng_en_q    <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + RWID'(1);
            // len_q = 0 wraps to all-ones, giving a full 2^RWID window
            if (cnt_q == len_q - RWID'(1)) begin
              state_q  <= DRAIN;
              rng_en_q <= 1'b0;
              done_q   <= grant_q;
            end
          end
        end
        DRAIN: begin
          // Normal exit and abort look the same here; done is already out.
          state_q     <= IDLE;
          grant_q     <= '0;
          grant_idx_q <= '0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grantIdx  = grant_idx_q;
  assign bus.rngEnable = rng_en_q;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rng_share_sched.sv
// tb_rng_share_sched
//   Directed bench for rng_share_sched with NREQ=4, RWID=4. Inputs change
//   on the falling edge, outputs are compared on the falling edge.
module tb_rng_share_sched;

  localparam int NREQ = 4;
  localparam int RWID = 4;
  localparam int IWID = 2;

  logic clk;
  logic rst_n;

  rng_share_sched_if #(.NREQ(NREQ), .RWID(RWID), .IWID(IWID)) bus ();

  rng_share_sched #(.NREQ(NREQ), .RWID(RWID), .IWID(IWID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] act_v;
  logic [10:0] exp_v;

  // Expected {grant, rngEnable, valid, done, busy} on cycle c (1 = first
  // cycle with grant) of a window of length len owned by g.
  function automatic logic [10:0] win_exp(input logic [3:0] g, input int len,
                                          input int c);
    logic [3:0] gg;
    logic [3:0] dd;
    gg = (c <= len + 1) ? g : 4'b0000;
    dd = (c == len + 1) ? g : 4'b0000;
    return {gg, 1'(c <= len), 1'(c >= 2 && c <= len + 1), dd, 1'(c <= len + 1)};
  endfunction

  function automatic logic [10:0] outs();
    return {bus.grant, bus.rngEnable, bus.valid, bus.done, bus.busy};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.abort = 1'b0;
    bus.cfgLen = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.abort = 1'b0;
    bus.cfgLen = 4'd5;
    repeat (2) @(negedge clk);
    act_v = outs();
    checks++;
    if (act_v !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs act=%b exp=%b", act_v, 11'd0);
    end
    checks++;
    if (bus.grantIdx !== 2'd0) begin
      errors++;
      $display("FAIL reset_idx act=%0d exp=0", bus.grantIdx);
    end
    bus.req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    act_v = outs();
    checks++;
    if (act_v !== 11'd0) begin
      errors++;
      $display("FAIL idle_no_req act=%b exp=%b", act_v, 11'd0);
    end
    $display("reset: outputs clear, idle without requests");
  endtask

  task automatic test_basic_window();
    do_reset();
    bus.req = 4'b0001;
    bus.cfgLen = 4'd5;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b0001, 5, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL basic c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c <= 6) begin
        checks++;
        if (bus.grantIdx !== 2'd0) begin
          errors++;
          $display("FAIL basic_idx c=%0d act=%0d exp=0", c, bus.grantIdx);
        end
      end
      if (c == 6) bus.req = '0;
    end
    $display("window: owner=0001 len=5");
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    do_reset();
    bus.req = 4'b1111;
    bus.cfgLen = 4'd2;
    for (int w = 0; w < 5; w++) begin
      g = 4'b0001 << (w % 4);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        exp_v = win_exp(g, 2, c);
        act_v = outs();
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL b2b w=%0d c=%0d act=%b exp=%b", w, c, act_v, exp_v);
        end
        if (c <= 3) begin
          checks++;
          if (bus.grantIdx !== 2'(w % 4)) begin
            errors++;
            $display("FAIL b2b_idx w=%0d act=%0d exp=%0d", w, bus.grantIdx, w % 4);
          end
        end
        if (w == 4 && c == 1) bus.req = '0;
      end
      $display("window: owner=%b len=2", g);
    end
  endtask

  task automatic test_full_length();
    // rrPtr is 1 here: req 0010 wins directly.
    bus.req = 4'b0010;
    bus.cfgLen = 4'd0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b0010, 16, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL full c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c == 1) bus.req = '0;
    end
    $display("window: owner=0010 len=0 (16 cycles)");
  endtask

  task automatic test_abort();
    // rrPtr is 2 here.
    bus.req = 4'b0100;
    bus.cfgLen = 4'd8;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b0100, 8, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL abort_run c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c == 1) bus.req = '0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    act_v = outs();
    checks++;
    if (act_v !== 11'd0) begin
      errors++;
      $display("FAIL abort_stop act=%b exp=%b", act_v, 11'd0);
    end
    // abort held in IDLE with a pending request: no grant may issue
    bus.req = 4'b0010;
    @(negedge clk);
    act_v = outs();
    checks++;
    if (act_v !== 11'd0) begin
      errors++;
      $display("FAIL abort_idle act=%b exp=%b", act_v, 11'd0);
    end
    bus.abort = 1'b0;
    bus.cfgLen = 4'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b0010, 3, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL abort_next c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c == 1) bus.req = '0;
    end
    $display("window: owner=0100 aborted, then owner=0010 len=3");
  endtask

  task automatic test_req_drop();
    // rrPtr is 2 here: scan 2,3 -> owner 3.
    bus.req = 4'b1000;
    bus.cfgLen = 4'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b1000, 3, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL req_drop c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c <= 4) begin
        checks++;
        if (bus.grantIdx !== 2'd3) begin
          errors++;
          $display("FAIL req_drop_idx c=%0d act=%0d exp=3", c, bus.grantIdx);
        end
      end
      if (c == 1) begin
        bus.req = '0;
        bus.cfgLen = 4'd7;
      end
    end
    $display("window: owner=1000 len=3, req dropped after grant");
  endtask

  task automatic test_async_reset();
    // rrPtr is 0 here: owner 2, leaving rrPtr=3 before the reset.
    bus.req = 4'b0100;
    bus.cfgLen = 4'd8;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    act_v = outs();
    checks++;
    if (act_v !== win_exp(4'b0100, 8, 2)) begin
      errors++;
      $display("FAIL areset_pre act=%b exp=%b", act_v, win_exp(4'b0100, 8, 2));
    end
    rst_n = 1'b0;
    #1;
    act_v = outs();
    checks++;
    if (act_v !== 11'd0) begin
      errors++;
      $display("FAIL areset_now act=%b exp=%b", act_v, 11'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1010;
    bus.cfgLen = 4'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_v = win_exp(4'b0010, 1, c);
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL areset_post c=%0d act=%b exp=%b", c, act_v, exp_v);
      end
      if (c == 1) bus.req = '0;
    end
    $display("window: reset mid-run, then owner=0010 len=1");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.cfgLen = '0;
    bus.abort = 1'b0;
    test_reset();
    test_basic_window();
    test_back_to_back();
    test_full_length();
    test_abort();
    test_req_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
